// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter:
// one-hot FSM encodings, owner encoding and the default strobe width.
package mem_arb_pkg;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_GNT_I = 5'b00010;
  localparam logic [4:0] ST_GNT_D = 5'b00100;
  localparam logic [4:0] ST_RSP_I = 5'b01000;
  localparam logic [4:0] ST_RSP_D = 5'b10000;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned STRB_W         = DEF_DATA_WIDTH / 8;

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// Combinational grant picker for the memory port arbiter.
// Default: fixed priority, data over instruction fetch.
// MEM_ARB_ROUND_ROBIN_EN: on contention the requester that did not own
// the port last goes first.
module arb_grant_sel
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic gnt_i,
  output logic gnt_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Alternate owners when both sides request in the same cycle
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      gnt_i = (last_owner == OWN_DATA);
      gnt_d = (last_owner == OWN_INST);
    end else begin
      gnt_i = req_i;
      gnt_d = req_d;
    end
  end
`else
  // last_owner is tracked by the top but has no effect on fixed priority
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Data channel always wins a tie
  always_comb begin
    gnt_d = req_d;
    gnt_i = req_i & ~req_d;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU fetch and data channels with at
// most one transaction in flight; read responses are routed back to the
// requester that issued them. Stores complete on the request ack.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (see arb_grant_sel).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  input  logic                    inst_req_valid,
  output logic                    inst_req_ack,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_rvalid,
  input  logic                    inst_rack,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_req_ack,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_rvalid,
  input  logic                    data_rack,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_req_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    mem_rack
);

  logic [4:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       data_req;
  logic       gnt_i, gnt_d;

  assign data_req = data_read | data_write;

  arb_grant_sel u_grant_sel (
    .req_i      (inst_req_valid),
    .req_d      (data_req),
    .last_owner (last_owner_q),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

  // Next-state and ownership: grant from IDLE, leave GNT on request ack,
  // leave RSP on the response handshake
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_d) begin
          state_d      = ST_GNT_D;
          last_owner_d = OWN_DATA;
        end else if (gnt_i) begin
          state_d      = ST_GNT_I;
          last_owner_d = OWN_INST;
        end
      end
      ST_GNT_I: if (mem_req_ack) state_d = ST_RSP_I;
      ST_GNT_D: if (mem_req_ack) state_d = data_write ? ST_IDLE : ST_RSP_D;
      ST_RSP_I: if (mem_rvalid && inst_rack) state_d = ST_IDLE;
      ST_RSP_D: if (mem_rvalid && data_rack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath routing: nothing reaches either side unless the state owns it
  always_comb begin
    mem_addr     = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    mem_rack     = 1'b0;
    inst_req_ack = 1'b0;
    inst_rdata   = '0;
    inst_rvalid  = 1'b0;
    data_req_ack = 1'b0;
    data_rdata   = '0;
    data_rvalid  = 1'b0;
    case (state_q)
      ST_GNT_I: begin
        mem_addr     = inst_addr;
        mem_read     = 1'b1;
        inst_req_ack = mem_req_ack;
      end
      ST_GNT_D: begin
        // read+write together is a store
        mem_addr     = data_addr;
        mem_write    = data_write;
        mem_read     = data_read & ~data_write;
        mem_wdata    = data_wdata;
        mem_wstrb    = data_wstrb;
        data_req_ack = mem_req_ack;
      end
      ST_RSP_I: begin
        inst_rdata  = mem_rdata;
        inst_rvalid = mem_rvalid;
        mem_rack    = inst_rack;
      end
      ST_RSP_D: begin
        data_rdata  = mem_rdata;
        data_rvalid = mem_rvalid;
        mem_rack    = data_rack;
      end
      default: ;
    endcase
  end

  // State and ownership registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_INST;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized transaction pairs checked against a transaction-level model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_req_valid;
  logic        inst_req_ack;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        inst_rack;
  logic [31:0] data_addr;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_req_ack;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        data_rack;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req_ack;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rack;

  int n_err = 0;
  int n_chk = 0;
  bit last_d = 1'b0;  // model of last owner: 1 = data

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ack(inst_req_ack),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rack(inst_rack),
    .data_addr(data_addr), .data_read(data_read), .data_write(data_write),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ack(data_req_ack),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rack(data_rack),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ack(mem_req_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rack(mem_rack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Arbiter must present nothing to memory or to either requester
  task automatic chk_quiet(input string tag);
    chk1({tag, ".mem_read"}, mem_read, 1'b0);
    chk1({tag, ".mem_write"}, mem_write, 1'b0);
    chk32({tag, ".mem_addr"}, mem_addr, 32'h0);
    chk32({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'h0);
    chk1({tag, ".inst_req_ack"}, inst_req_ack, 1'b0);
    chk1({tag, ".data_req_ack"}, data_req_ack, 1'b0);
    chk1({tag, ".inst_rvalid"}, inst_rvalid, 1'b0);
    chk1({tag, ".data_rvalid"}, data_rvalid, 1'b0);
    chk1({tag, ".mem_rack"}, mem_rack, 1'b0);
    chk32({tag, ".inst_rdata"}, inst_rdata, 32'h0);
    chk32({tag, ".data_rdata"}, data_rdata, 32'h0);
  endtask

  // Idle cycle with a spurious memory response and both racks high
  task automatic idle_probe(input string tag);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    inst_rack  = 1'b1;
    data_rack  = 1'b1;
    #1;
    chk_quiet(tag);
    mem_rvalid = 1'b0;
    inst_rack  = 1'b0;
    data_rack  = 1'b0;
  endtask

  // Memory side of one granted transaction, entered in the grant cycle
  task automatic serve(input bit own_d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] rdata, input int unsigned ackd,
                       input int unsigned rvd, input int unsigned rackd);
    bit done;
    for (int unsigned k = 0; k <= ackd; k++) begin
      mem_req_ack = (k == ackd);
      mem_rvalid  = 1'($urandom_range(0, 1));
      inst_rack   = 1'b1;
      data_rack   = 1'b1;
      #1;
      chk32("gnt.addr", mem_addr, addr);
      chk1("gnt.read", mem_read, !wr);
      chk1("gnt.write", mem_write, wr);
      chk32("gnt.wstrb", 32'(mem_wstrb), own_d ? 32'(wstrb) : 32'h0);
      if (own_d) chk32("gnt.wdata", mem_wdata, wdata);
      chk1("gnt.own_ack", own_d ? data_req_ack : inst_req_ack, k == ackd);
      chk1("gnt.other_ack", own_d ? inst_req_ack : data_req_ack, 1'b0);
      chk1("gnt.rvalid", inst_rvalid | data_rvalid, 1'b0);
      chk1("gnt.mem_rack", mem_rack, 1'b0);
      tick;
    end
    mem_req_ack = 1'b0;
    mem_rvalid  = 1'b0;
    inst_rack   = 1'b0;
    data_rack   = 1'b0;
    if (!wr) begin
      done = 1'b0;
      for (int unsigned c = 0; !done && c < 40; c++) begin
        mem_rvalid = (c >= rvd);
        mem_rdata  = mem_rvalid ? rdata : $urandom;
        inst_rack  = own_d ? 1'($urandom_range(0, 1)) : (c >= rackd);
        data_rack  = own_d ? (c >= rackd) : 1'($urandom_range(0, 1));
        #1;
        chk1("rsp.own_rvalid", own_d ? data_rvalid : inst_rvalid, c >= rvd);
        if (c >= rvd) chk32("rsp.own_rdata", own_d ? data_rdata : inst_rdata, rdata);
        chk1("rsp.other_rvalid", own_d ? inst_rvalid : data_rvalid, 1'b0);
        chk32("rsp.other_rdata", own_d ? inst_rdata : data_rdata, 32'h0);
        chk1("rsp.mem_rack", mem_rack, c >= rackd);
        chk1("rsp.mem_req", mem_read | mem_write, 1'b0);
        chk1("rsp.acks", inst_req_ack | data_req_ack, 1'b0);
        done = (c >= rvd) && (c >= rackd);
        tick;
      end
      mem_rvalid = 1'b0;
      inst_rack  = 1'b0;
      data_rack  = 1'b0;
    end
  endtask

  // Issue fetch and/or data request together; model picks the service order
  task automatic txn(input bit hi, input logic [31:0] ia, input logic [31:0] ird,
                     input bit hd, input bit dwr, input bit drd,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dst,
                     input logic [31:0] drdat, input int unsigned ackd,
                     input int unsigned rvd, input int unsigned rackd);
    bit first_d;
    bit wr;
    inst_req_valid = hi;
    inst_addr      = ia;
    data_write     = hd & dwr;
    data_read      = hd & drd;
    data_addr      = da;
    data_wdata     = dwd;
    data_wstrb     = dst;
    wr             = hd & dwr;
    idle_probe("arb");
    tick;
    if (hi && hd) first_d = RR ? !last_d : 1'b1;
    else          first_d = hd;
    last_d = first_d;
    if (first_d) begin
      serve(1'b1, wr, da, dwd, dst, drdat, ackd, rvd, rackd);
      data_read = 1'b0; data_write = 1'b0;
    end else begin
      serve(1'b0, 1'b0, ia, 32'h0, 4'h0, ird, ackd, rvd, rackd);
      inst_req_valid = 1'b0;
    end
    idle_probe("between");
    tick;
    if (hi && hd) begin
      last_d = !first_d;
      if (first_d) begin
        serve(1'b0, 1'b0, ia, 32'h0, 4'h0, ird, rackd, ackd, rvd);
        inst_req_valid = 1'b0;
      end else begin
        serve(1'b1, wr, da, dwd, dst, drdat, rackd, ackd, rvd);
        data_read = 1'b0; data_write = 1'b0;
      end
      idle_probe("after");
      tick;
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_addr = '0; inst_req_valid = 1'b0; inst_rack = 1'b0;
    data_addr = '0; data_read = 1'b0; data_write = 1'b0;
    data_wdata = '0; data_wstrb = '0; data_rack = 1'b0;
    mem_req_ack = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    tick;
    tick;
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    tick;

    // lone fetch: ack after 2 cycles, rvalid after 3
    txn(1'b1, 32'h0000_0010, 32'h2408_0005, 1'b0, 1'b0, 1'b0,
        32'h0, 32'h0, 4'h0, 32'h0, 2, 3, 0);
    // store: no response phase
    txn(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0,
        32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1, 0, 0);
    // simultaneous fetch and load
    txn(1'b1, 32'h0000_0040, 32'h1111_2222, 1'b1, 1'b0, 1'b1,
        32'h0000_0200, 32'h0, 4'h3, 32'h3333_4444, 0, 1, 1);
    // response isolation: data_rack held low 4 cycles
    txn(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1,
        32'h0000_0300, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, 4);
    // read+write together behaves as a store
    txn(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1,
        32'h0000_0400, 32'h0BAD_F00D, 4'h5, 32'h0, 0, 0, 0);

    // spurious responses while idle
    for (int i = 0; i < 4; i++) begin
      idle_probe("spurious");
      tick;
    end

    // reset during a data grant
    data_write = 1'b1; data_addr = 32'h0000_0500;
    data_wdata = 32'h5555_AAAA; data_wstrb = 4'hC;
    idle_probe("rst.arb");
    tick;
    #1;
    chk1("rst.in_gnt_write", mem_write, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    idle_probe("rst.after");
    data_write = 1'b0;
    tick;
    last_d = 1'b0;
    txn(1'b1, 32'h0000_0600, 32'h7777_8888, 1'b0, 1'b0, 1'b0,
        32'h0, 32'h0, 4'h0, 32'h0, 1, 1, 0);

    // randomized transaction pairs
    for (int it = 0; it < 40; it++) begin
      bit hi, hd, dwr, drd;
      hi  = 1'($urandom_range(0, 1));
      hd  = 1'($urandom_range(0, 1));
      if (!hi && !hd) hd = 1'b1;
      dwr = 1'($urandom_range(0, 1));
      drd = dwr ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(hi, $urandom, $urandom, hd, dwr, drd, $urandom, $urandom,
          4'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
